// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with a long-latency result buffer and scoreboard.
// Writeback wins the port; the buffer head, then a bypassing long-latency result, fill idle cycles.
module rf_write_arbiter #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dec_valid_i,
  input  logic [4:0]      dec_r1_addr_i,
  input  logic [4:0]      dec_r2_addr_i,
  input  logic [4:0]      dec_rd_addr_i,
  input  logic            dec_rd_we_i,
  input  logic            dec_long_i,
  output logic            stall_o,
  output logic            fwd_a_o,
  output logic            fwd_b_o,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            ll_valid_i,
  input  logic [4:0]      ll_rd_addr_i,
  input  logic [XLEN-1:0] ll_data_i,
  output logic            ll_ready_o,
  output logic            rf_rw_en_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic [NREG-1:0]  r_busy;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_buf_addr [LQ_DEPTH];
  logic [XLEN-1:0]  r_buf_data [LQ_DEPTH];

  logic            w_full;
  logic            w_empty;
  logic            w_ll_fire;
  logic            w_sel_valid;
  logic            w_sel_long;
  logic [4:0]      w_sel_addr;
  logic [XLEN-1:0] w_sel_data;
  logic            w_pop;
  logic            w_push;
  logic            w_ll_wr;
  logic            w_stall;
  logic            w_issue;
  logic [NREG-1:0] w_busy_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full     = (r_count == CNT_W'(LQ_DEPTH));
  assign w_empty    = (r_count == '0);
  assign ll_ready_o = !rst_i && !w_full;
  assign w_ll_fire  = ll_valid_i && ll_ready_o;

  // A long-latency result that loses the port is always pushed; it never waits upstream
  // unless the buffer is full.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_long  = 1'b0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    if (wb_valid_i) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = wb_rd_addr_i;
      w_sel_data  = wb_data_i;
      w_push      = w_ll_fire;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
      w_sel_long  = 1'b1;
      w_sel_addr  = r_buf_addr[r_head];
      w_sel_data  = r_buf_data[r_head];
      w_pop       = 1'b1;
      w_push      = w_ll_fire;
    end else if (w_ll_fire) begin
      w_sel_valid = 1'b1;
      w_sel_long  = 1'b1;
      w_sel_addr  = ll_rd_addr_i;
      w_sel_data  = ll_data_i;
    end
  end

  assign rf_rw_en_o = !rst_i && w_sel_valid && (w_sel_addr != 5'd0);
  assign rf_waddr_o = w_sel_addr;
  assign rf_wdata_o = w_sel_data;
  assign fwd_a_o    = rf_rw_en_o && (rf_waddr_o == dec_r1_addr_i);
  assign fwd_b_o    = rf_rw_en_o && (rf_waddr_o == dec_r2_addr_i);
  assign w_ll_wr    = w_sel_long && rf_rw_en_o;

  // A full buffer stalls decode outright so bubbles appear on writeback and the buffer drains.
  assign w_stall = dec_valid_i && !rst_i &&
                   (r_busy[dec_r1_addr_i] || r_busy[dec_r2_addr_i] ||
                    (dec_rd_we_i && r_busy[dec_rd_addr_i]) ||
                    (dec_long_i && w_full) || w_full);
  assign stall_o = w_stall;

  assign w_issue = dec_valid_i && !w_stall && dec_long_i && dec_rd_we_i &&
                   (dec_rd_addr_i != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign w_busy_next[gi] =
            (r_busy[gi] && !(w_ll_wr && (w_sel_addr == 5'(gi)))) ||
            (w_issue && (dec_rd_addr_i == 5'(gi)));
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      if (w_push) begin
        r_tail <= ptr_inc(r_tail);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf_addr[r_tail] <= ll_rd_addr_i;
      r_buf_data[r_tail] <= ll_data_i;
    end
  end

  a_wb_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    !(wb_valid_i && (wb_rd_addr_i != 5'd0) && r_busy[wb_rd_addr_i]));

endmodule
